// File: rtl/ysyx_22050019_ifu_pkg.sv
// ysyx_22050019_ifu_pkg: shared encodings and constants for the instruction fetch unit
package ysyx_22050019_ifu_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;
  localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam int          INST_WIDTH = 32;
endpackage

// File: rtl/ysyx_22050019_ifu.sv
// ysyx_22050019_ifu: PC owner issuing one aligned icache read per instruction, with redirect and stale-response discard
module ysyx_22050019_ifu
  import ysyx_22050019_ifu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          INST_W     = INST_WIDTH,
  parameter logic [63:0] RST_PC     = RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  input  logic                  r_data_valid_i,
  output logic                  r_data_ready_o,
  input  logic [1:0]            r_resp_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_W-1:0]     inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_err_o,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);
  ifu_state_e            state_q;
  logic [ADDR_WIDTH-1:0] pc_q, addr_q, pc_out_q;
  logic [INST_W-1:0]     inst_q;
  logic                  stale_q, err_q;
  logic [ADDR_WIDTH-1:0] rpc, pc_inc, wait_pc, out_pc;
  logic [INST_W-1:0]     inst_sel;
  always_comb begin
    rpc      = redirect_pc_i & ~ADDR_WIDTH'(3);
    pc_inc   = pc_q + ADDR_WIDTH'(4);
    wait_pc  = redirect_valid_i ? rpc : pc_q;
    out_pc   = redirect_valid_i ? rpc : pc_inc;
    inst_sel = pc_q[2] ? r_data_i[2*INST_W-1:INST_W] : r_data_i[INST_W-1:0];
  end
  // addr_q is latched on entry to S_REQ so a redirect there cannot disturb the pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= ADDR_WIDTH'(RST_PC);
      addr_q   <= '0;
      stale_q  <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          addr_q  <= {pc_q[ADDR_WIDTH-1:3], 3'b000};
        end
        S_REQ: begin
          if (redirect_valid_i) begin
            pc_q    <= rpc;
            stale_q <= 1'b1;
          end
          if (ar_ready_i) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (r_data_valid_i) begin
            if (stale_q || redirect_valid_i) begin
              stale_q <= 1'b0;
              pc_q    <= wait_pc;
              addr_q  <= {wait_pc[ADDR_WIDTH-1:3], 3'b000};
              state_q <= S_REQ;
            end else begin
              inst_q   <= inst_sel;
              pc_out_q <= pc_q;
              err_q    <= r_resp_i != RESP_OKAY;
              state_q  <= S_OUT;
            end
          end else if (redirect_valid_i) begin
            pc_q    <= rpc;
            stale_q <= 1'b1;
          end
        end
        default: begin
          if (redirect_valid_i || inst_ready_i) begin
            pc_q    <= out_pc;
            addr_q  <= {out_pc[ADDR_WIDTH-1:3], 3'b000};
            state_q <= S_REQ;
          end
        end
      endcase
    end
  end
  always_comb begin
    ar_valid_o     = state_q == S_REQ;
    r_data_ready_o = state_q == S_WAIT;
    inst_valid_o   = state_q == S_OUT;
    ar_addr_o      = addr_q;
    inst_o         = inst_q;
    pc_o           = pc_out_q;
    inst_err_o     = err_q;
  end
endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// tb_ysyx_22050019_ifu: directed self-checking bench acting as icache and IDU
module tb_ysyx_22050019_ifu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ar_valid_o, ar_ready_i = 1'b0;
  logic [63:0] ar_addr_o;
  logic        r_data_valid_i = 1'b0, r_data_ready_o;
  logic [1:0]  r_resp_i = 2'b00;
  logic [63:0] r_data_i = '0;
  logic        inst_valid_o, inst_ready_i = 1'b0, inst_err_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  int          n_cmp = 0, n_bad = 0;
  ysyx_22050019_ifu dut (
    .clk(clk), .rst(rst),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_data_valid_i(r_data_valid_i), .r_data_ready_o(r_data_ready_o),
    .r_resp_i(r_resp_i), .r_data_i(r_data_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .pc_o(pc_o), .inst_err_o(inst_err_o),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_ar();
    int n = 0;
    while (!ar_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("ar_valid", ar_valid_o, 1);
  endtask
  task automatic wait_inst();
    int n = 0;
    while (!inst_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("inst_valid", inst_valid_o, 1);
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ar_valid"}, ar_valid_o, 0);
    chk({tag, "_r_ready"}, r_data_ready_o, 0);
    chk({tag, "_inst_valid"}, inst_valid_o, 0);
    chk({tag, "_inst"}, inst_o, 0);
    chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_err"}, inst_err_o, 0);
  endtask
  task automatic fetch(input logic [63:0] a, input int ad, input int rd,
                       input logic [63:0] d, input logic [1:0] rs);
    wait_ar();
    chk("ar_addr", ar_addr_o, a);
    repeat (ad) begin
      @(negedge clk);
      chk("ar_hold_valid", ar_valid_o, 1);
      chk("ar_hold_addr", ar_addr_o, a);
    end
    ar_ready_i = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    chk("r_ready", r_data_ready_o, 1);
    repeat (rd) @(negedge clk);
    r_data_valid_i = 1'b1; r_data_i = d; r_resp_i = rs;
    @(negedge clk);
    r_data_valid_i = 1'b0; r_resp_i = 2'b00;
  endtask
  task automatic take(input logic [31:0] ei, input logic [63:0] ep, input logic ee,
                      input int bp, input logic rv, input logic [63:0] rp);
    wait_inst();
    chk("inst", inst_o, ei);
    chk("pc", pc_o, ep);
    chk("err", inst_err_o, ee);
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", inst_valid_o, 1);
      chk("bp_inst", inst_o, ei);
      chk("bp_pc", pc_o, ep);
      chk("bp_no_ar", ar_valid_o, 0);
    end
    inst_ready_i = 1'b1; redirect_valid_i = rv; redirect_pc_i = rp;
    @(negedge clk);
    inst_ready_i = 1'b0; redirect_valid_i = 1'b0;
    chk("inst_drop", inst_valid_o, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    // Two halves of the same aligned word
    fetch(64'h8000_0000, 0, 0, 64'h00100093_00000513, 2'b00);
    take(32'h00000513, 64'h8000_0000, 0, 0, 0, 0);
    fetch(64'h8000_0000, 0, 1, 64'h00100093_00000513, 2'b00);
    take(32'h00100093, 64'h8000_0004, 0, 5, 0, 0);
    // Redirect while waiting; late response must be dropped
    wait_ar();
    chk("c_addr", ar_addr_o, 64'h8000_0008);
    ar_ready_i = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0100;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    repeat (3) begin
      chk("c_wait_ready", r_data_ready_o, 1);
      chk("c_no_inst", inst_valid_o, 0);
      @(negedge clk);
    end
    r_data_valid_i = 1'b1; r_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    r_data_valid_i = 1'b0;
    chk("c_discard", inst_valid_o, 0);
    chk("c_rereq", ar_valid_o, 1);
    fetch(64'h8000_0100, 0, 0, 64'h11111111_22222222, 2'b00);
    take(32'h22222222, 64'h8000_0100, 0, 0, 1, 64'h8000_0040);
    // Error flagged only on the faulting instruction
    fetch(64'h8000_0040, 1, 0, 64'h33333333_44444444, 2'b10);
    take(32'h44444444, 64'h8000_0040, 1, 0, 0, 0);
    fetch(64'h8000_0040, 0, 0, 64'h33333333_44444444, 2'b00);
    take(32'h33333333, 64'h8000_0044, 0, 0, 0, 0);
    // Redirect while request is stalled; low target bits are forced to 0
    wait_ar();
    chk("g_addr", ar_addr_o, 64'h8000_0048);
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0203;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    chk("g_hold0", ar_addr_o, 64'h8000_0048);
    @(negedge clk);
    chk("g_hold1", ar_addr_o, 64'h8000_0048);
    ar_ready_i = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    r_data_valid_i = 1'b1; r_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    r_data_valid_i = 1'b0;
    chk("g_discard", inst_valid_o, 0);
    fetch(64'h8000_0200, 0, 0, 64'h55555555_66666666, 2'b00);
    take(32'h66666666, 64'h8000_0200, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    // PC wraps past the top of the address space
    fetch(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 64'h77777777_88888888, 2'b00);
    take(32'h77777777, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
    fetch(64'h0, 0, 0, 64'h99999999_AAAAAAAA, 2'b00);
    take(32'hAAAAAAAA, 64'h0, 0, 0, 0, 0);
    // Reset in the middle of a transaction
    wait_ar();
    chk("k_addr", ar_addr_o, 64'h0);
    ar_ready_i = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    fetch(64'h8000_0000, 0, 0, 64'h00100093_00000513, 2'b00);
    take(32'h00000513, 64'h8000_0000, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22050019_ifu.md
Name: ysyx_22050019_ifu

Overview:
Instruction fetch stage directly upstream of the 2-way instruction cache. It owns the PC and issues one 64-bit-aligned read per instruction on the cache's IFU-side valid/ready interface. It extracts the 32-bit instruction selected by pc[2] and holds it in an output register for decode (IDU) under a valid/ready handshake. It also handles redirects (branch/jump/trap) from later stages, including discarding a response that is already in flight.

Parameters:
ADDR_WIDTH, 64, PC and cache request address width
DATA_WIDTH, 64, cache response data width
INST_WIDTH, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
ar_valid_o  out  1  fetch request valid to icache
ar_ready_i  in  1  icache accepts request
ar_addr_o  out  ADDR_WIDTH  request address = {pc[63:3],3'b0}
r_data_valid_i  in  1  icache response valid (may be combinational from the cache)
r_data_ready_o  out  1  IFU accepts response
r_resp_i  in  2  response status; 2'b00 = OKAY
r_data_i  in  DATA_WIDTH  aligned 64-bit fetch data
inst_valid_o  out  1  instruction valid to IDU
inst_ready_i  in  1  IDU accepts instruction
inst_o  out  INST_WIDTH  fetched instruction
pc_o  out  ADDR_WIDTH  PC of inst_o
inst_err_o  out  1  fetch access fault (r_resp_i != 0)
redirect_valid_i  in  1  redirect request from EXU/WBU
redirect_pc_i  in  ADDR_WIDTH  redirect target; bits [1:0] forced to 0

Behaviour:
- Reset (rst=1 at a clk edge): state=S_IDLE, pc=RESET_PC, stale=0, ar_valid_o=0, r_data_ready_o=0, inst_valid_o=0, inst_o=0, pc_o=0, inst_err_o=0.
- States:
  - S_IDLE: always moves to S_REQ next cycle.
  - S_REQ: ar_valid_o=1.
  - S_WAIT: r_data_ready_o=1.
  - S_OUT: inst_valid_o=1.
- S_REQ:
  - ar_valid_o and ar_addr_o stay stable until ar_valid_o&ar_ready_i.
  - On handshake, go to S_WAIT.
  - A redirect in S_REQ updates pc and sets stale=1. The already-asserted address is not changed.
- S_WAIT, response handshake (r_data_valid_i&r_data_ready_o):
  - stale=0 and no redirect this cycle: inst_o = pc[2] ? r_data_i[63:32] : r_data_i[31:0]; pc_o=pc; inst_err_o=|r_resp_i; go to S_OUT.
  - stale=1 or redirect this cycle: discard the data, clear stale, go to S_REQ with the current or redirected pc.
- S_WAIT, redirect with no response this cycle: update pc, set stale=1, stay in S_WAIT.
- S_OUT:
  - inst_valid_o held until inst_valid_o&inst_ready_i. On handshake: pc<=pc+4, go to S_REQ. inst_valid_o=0 the following cycle.
  - Redirect in S_OUT (including the same cycle as an IDU handshake): the instruction is squashed, pc<=redirect_pc_i, go to S_REQ. Redirect has priority over handshake.
- Latency:
  - Request to instruction presentation is at least 2 cycles: S_REQ handshake, then S_WAIT response registered into S_OUT.
  - No combinational path from r_data_i to inst_o.
  - Minimum 3 cycles per instruction on back-to-back hits.
- At most one outstanding request. The stale flag guarantees exactly one response is consumed per accepted request.
- pc arithmetic is modulo 2^ADDR_WIDTH: pc+4 wraps from all-ones-minus-3 to 0.
- r_resp_i error does not stop fetch. The error is only flagged with the instruction.
- rst asserted mid-transaction returns to reset values at the next edge. The icache is reset by the same rst, so no response is drained.

Decomposition:
- Shared package: state encoding (S_IDLE=0, S_REQ=1, S_WAIT=2, S_OUT=3), RESET_PC, RESP_OKAY=2'b00, INST_WIDTH.
- Single module; no sub-module is natural.

Test Plan:
- Reset then hit: icache accepts in 1 cycle and returns 64'h00100093_00000513 at pc 8000_0000 → inst_o=32'h00000513, pc_o=8000_0000; next fetch at 8000_0004 yields 32'h00100093 with ar_addr_o still 8000_0000.
- IDU backpressure: inst_ready_i=0 for 5 cycles → inst_valid_o, inst_o, pc_o stable; no new ar_valid_o until the handshake.
- Redirect during S_WAIT to 8000_0100, response arrives 4 cycles later → response discarded, next ar_addr_o=8000_0100, no instruction issued for the old pc.
- Redirect in the same cycle as an S_OUT handshake (target 8000_0040) → next ar_addr_o=8000_0040, pc_o of the next instruction=8000_0040, not pc+4.
- Error response: r_resp_i=2'b10 → inst_valid_o=1, inst_err_o=1; the following instruction has inst_err_o=0.
- Redirect in S_REQ while ar_ready_i=0 → ar_addr_o unchanged until accepted; that response is dropped; the redirected address is fetched next.
